// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: data-memory request/handshake, byte lanes, load formatting, MEM/WB register.
// Optional `define MISALIGN_TRAP_EN suppresses misaligned accesses and reports them on misalign_W.
module mem_access_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_M,
  input  logic                  MemRead_M,
  input  logic                  MemWrite_M,
  input  logic                  MemtoReg_M,
  input  logic                  RegWrite_M,
  input  logic [2:0]            funct3_M,
  input  logic [4:0]            rd_M,
  input  logic [DAT_WIDTH-1:0]  ALU_result_M,
  input  logic [DAT_WIDTH-1:0]  wdata_M,
  input  logic [ADDR_WIDTH-1:0] PC_4M,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DAT_WIDTH-1:0]  dmem_wdata,
  input  logic [DAT_WIDTH-1:0]  dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  stall_M,
  output logic                  valid_W,
  output logic                  MemtoReg_W,
  output logic                  RegWrite_W,
  output logic [4:0]            rd_W,
  output logic [ADDR_WIDTH-1:0] PC_4W,
  output logic [DAT_WIDTH-1:0]  ALU_result_W,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalign_W,
`endif
  output logic [DAT_WIDTH-1:0]  rdata_W
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [1:0]           off;
  logic                 is_byte, is_half;
  logic                 mem_op, misalign, access;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DAT_WIDTH-1:0] ld_fmt;

  logic                  valid_q, valid_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  regwrite_q, regwrite_d;
  logic                  misalign_q, misalign_d;
  logic [4:0]            rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
  logic [DAT_WIDTH-1:0]  alu_q, alu_d;
  logic [DAT_WIDTH-1:0]  rdata_q, rdata_d;

  always_comb begin
    off     = ALU_result_M[1:0];
    is_byte = (funct3_M[1:0] == 2'b00);
    is_half = (funct3_M[1:0] == 2'b01);
    mem_op  = valid_M & (MemRead_M | MemWrite_M);
`ifdef MISALIGN_TRAP_EN
    misalign = mem_op & ((is_half & off[0]) | (!is_byte && !is_half && (off != 2'b00)));
`else
    misalign = 1'b0;
`endif
    access = mem_op & !misalign;
  end

  // Request/stall gated by rst_n so an abandoned access is dropped immediately.
  always_comb begin
    state_d  = state_q;
    dmem_req = rst_n & (access | (state_q == S_WAIT));
    stall_M  = rst_n & access & !dmem_ready;
    dmem_we  = MemWrite_M;
    case (state_q)
      S_IDLE: if (access && !dmem_ready) state_d = S_WAIT;
      S_WAIT: if (dmem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_addr  = {ALU_result_M[ADDR_WIDTH-1:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = wdata_M;
    if (MemWrite_M) begin
      if (is_byte) begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{wdata_M[7:0]}};
      end else if (is_half) begin
        dmem_be    = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{wdata_M[15:0]}};
      end
    end
  end

  always_comb begin
    case (off)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_M)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // A stall inserts a bubble: only valid/RegWrite drop, payload fields hold.
  always_comb begin
    valid_d    = valid_q;
    memtoreg_d = memtoreg_q;
    regwrite_d = regwrite_q;
    misalign_d = misalign_q;
    rd_d       = rd_q;
    pc4_d      = pc4_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    if (stall_M) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else begin
      valid_d    = valid_M;
      memtoreg_d = MemtoReg_M;
      regwrite_d = RegWrite_M & valid_M & !misalign;
      misalign_d = misalign;
      rd_d       = rd_M;
      pc4_d      = PC_4M;
      alu_d      = ALU_result_M;
      rdata_d    = (valid_M && MemRead_M && !misalign) ? ld_fmt : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= '0;
      pc4_q      <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
      rd_q       <= rd_d;
      pc4_q      <= pc4_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
    end
  end

  assign valid_W      = valid_q;
  assign MemtoReg_W   = memtoreg_q;
  assign RegWrite_W   = regwrite_q;
  assign rd_W         = rd_q;
  assign PC_4W        = pc4_q;
  assign ALU_result_W = alu_q;
  assign rdata_W      = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_W   = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (covers MISALIGN_TRAP_EN when defined).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_M, MemRead_M, MemWrite_M, MemtoReg_M, RegWrite_M;
  logic [2:0]  funct3_M;
  logic [4:0]  rd_M;
  logic [31:0] ALU_result_M, wdata_M, PC_4M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall_M, valid_W, MemtoReg_W, RegWrite_W;
  logic [4:0]  rd_W;
  logic [31:0] PC_4W, ALU_result_W, rdata_W;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_W;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_M(valid_M), .MemRead_M(MemRead_M),
    .MemWrite_M(MemWrite_M), .MemtoReg_M(MemtoReg_M), .RegWrite_M(RegWrite_M),
    .funct3_M(funct3_M), .rd_M(rd_M), .ALU_result_M(ALU_result_M), .wdata_M(wdata_M),
    .PC_4M(PC_4M), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .stall_M(stall_M), .valid_W(valid_W),
    .MemtoReg_W(MemtoReg_W), .RegWrite_W(RegWrite_W), .rd_W(rd_W), .PC_4W(PC_4W),
    .ALU_result_W(ALU_result_W),
`ifdef MISALIGN_TRAP_EN
    .misalign_W(misalign_W),
`endif
    .rdata_W(rdata_W)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                       input logic rdy, input logic regw, input logic [4:0] rd);
    valid_M = v; MemRead_M = rd_en; MemWrite_M = wr_en; funct3_M = f3;
    ALU_result_M = addr; wdata_M = wd; dmem_rdata = rdat; dmem_ready = rdy;
    RegWrite_M = regw; MemtoReg_M = rd_en; rd_M = rd; PC_4M = addr + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick(); tick();
    checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL rst_valid_W got=%0h exp=0", valid_W); end
    checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL rst_RegWrite_W got=%0h exp=0", RegWrite_W); end
    checks++; if (rdata_W !== 32'h0) begin errors++; $display("FAIL rst_rdata_W got=%h exp=0", rdata_W); end
    checks++; if (PC_4W !== 32'h0) begin errors++; $display("FAIL rst_PC_4W got=%h exp=0", PC_4W); end
    // LW stuck in WAIT, then reset for one edge
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 5'd3);
    checks++; if (stall_M !== 1'b1) begin errors++; $display("FAIL rstw_stall got=%0h exp=1", stall_M); end
    tick();
    rst_n = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstw_req_in_rst got=%0h exp=0", dmem_req); end
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL rstw_stall_in_rst got=%0h exp=0", stall_M); end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstw_req_after got=%0h exp=0", dmem_req); end
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL rstw_stall_after got=%0h exp=0", stall_M); end
    checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL rstw_valid_W got=%0h exp=0", valid_W); end
    checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL rstw_RegWrite_W got=%0h exp=0", RegWrite_W); end
    checks++; if (rdata_W !== 32'h0) begin errors++; $display("FAIL rstw_rdata_W got=%h exp=0", rdata_W); end
    tick();
    checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL rstw_late_ready got=%0h exp=0", valid_W); end
  endtask

  task automatic test_load_byte();
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80000000, 1'b1, 1'b1, 5'd7);
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL lb_stall got=%0h exp=0", stall_M); end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lb_req got=%0h exp=1", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lb_we got=%0h exp=0", dmem_we); end
    checks++; if (dmem_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got=%h exp=00001000", dmem_addr); end
    checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL lb_be got=%b exp=1111", dmem_be); end
    tick();
    checks++; if (rdata_W !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata_W); end
    checks++; if (valid_W !== 1'b1) begin errors++; $display("FAIL lb_valid_W got=%0h exp=1", valid_W); end
    checks++; if (RegWrite_W !== 1'b1) begin errors++; $display("FAIL lb_RegWrite_W got=%0h exp=1", RegWrite_W); end
    checks++; if (rd_W !== 5'd7) begin errors++; $display("FAIL lb_rd_W got=%0d exp=7", rd_W); end
    checks++; if (MemtoReg_W !== 1'b1) begin errors++; $display("FAIL lb_MemtoReg_W got=%0h exp=1", MemtoReg_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80000000, 1'b1, 1'b1, 5'd7);
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL lbu_stall got=%0h exp=0", stall_M); end
    tick();
    checks++; if (rdata_W !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got=%h exp=00000080", rdata_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h1001, 32'h0, 32'h11227F44, 1'b1, 1'b1, 5'd8);
    tick();
    checks++; if (rdata_W !== 32'h0000007F) begin errors++; $display("FAIL lb1_rdata got=%h exp=0000007f", rdata_W); end
  endtask

  task automatic test_store_wait();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 1'b0, 1'b0, 5'd9);
    for (int i = 0; i < 2; i++) begin
      checks++; if (stall_M !== 1'b1) begin errors++; $display("FAIL sh_stall[%0d] got=%0h exp=1", i, stall_M); end
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sh_req[%0d] got=%0h exp=1", i, dmem_req); end
      checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sh_we[%0d] got=%0h exp=1", i, dmem_we); end
      checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be[%0d] got=%b exp=1100", i, dmem_be); end
      checks++; if (dmem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata[%0d] got=%h exp=beefbeef", i, dmem_wdata); end
      tick();
      checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL sh_bubble[%0d] got=%0h exp=0", i, valid_W); end
      checks++; if (rd_W !== 5'd8) begin errors++; $display("FAIL sh_hold_rd[%0d] got=%0d exp=8", i, rd_W); end
    end
    dmem_ready = 1'b1; #1;
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL sh_done_stall got=%0h exp=0", stall_M); end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sh_done_req got=%0h exp=1", dmem_req); end
    tick();
    checks++; if (valid_W !== 1'b1) begin errors++; $display("FAIL sh_valid_W got=%0h exp=1", valid_W); end
    checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL sh_RegWrite_W got=%0h exp=0", RegWrite_W); end
    checks++; if (rd_W !== 5'd9) begin errors++; $display("FAIL sh_rd_W got=%0d exp=9", rd_W); end
  endtask

  task automatic test_store_lanes();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h2001, 32'h123456A5, 32'h0, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_be !== 4'b0010) begin errors++; $display("FAIL sb_be got=%b exp=0010", dmem_be); end
    checks++; if (dmem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", dmem_wdata); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h2003, 32'h0000003C, 32'h0, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL sb3_be got=%b exp=1000", dmem_be); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h2000, 32'hFFFF1357, 32'h0, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_be !== 4'b0011) begin errors++; $display("FAIL sh0_be got=%b exp=0011", dmem_be); end
    checks++; if (dmem_wdata !== 32'h13571357) begin errors++; $display("FAIL sh0_wdata got=%h exp=13571357", dmem_wdata); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h2004, 32'h12345678, 32'h0, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got=%b exp=1111", dmem_be); end
    checks++; if (dmem_wdata !== 32'h12345678) begin errors++; $display("FAIL sw_wdata got=%h exp=12345678", dmem_wdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h3002, 32'h0, 32'hF00D1234, 1'b1, 1'b1, 5'd10);
    tick();
    checks++; if (rdata_W !== 32'h0000F00D) begin errors++; $display("FAIL lhu_rdata got=%h exp=0000f00d", rdata_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h3002, 32'h0, 32'hF00D1234, 1'b1, 1'b1, 5'd11);
    tick();
    checks++; if (rdata_W !== 32'hFFFFF00D) begin errors++; $display("FAIL lh_rdata got=%h exp=fffff00d", rdata_W); end
    checks++; if (valid_W !== 1'b1) begin errors++; $display("FAIL lh_valid_W got=%0h exp=1", valid_W); end
    checks++; if (rd_W !== 5'd11) begin errors++; $display("FAIL lh_rd_W got=%0d exp=11", rd_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h3000, 32'h0, 32'hF00D1234, 1'b1, 1'b1, 5'd12);
    tick();
    checks++; if (rdata_W !== 32'h00001234) begin errors++; $display("FAIL lh0_rdata got=%h exp=00001234", rdata_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 32'hF00D1234, 1'b1, 1'b1, 5'd13);
    tick();
    checks++; if (rdata_W !== 32'hF00D1234) begin errors++; $display("FAIL lw_other_f3 got=%h exp=f00d1234", rdata_W); end
  endtask

  task automatic test_alu_op();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd5);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got=%0h exp=0", dmem_req); end
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL alu_stall got=%0h exp=0", stall_M); end
    tick();
    checks++; if (ALU_result_W !== 32'h12345678) begin errors++; $display("FAIL alu_result_W got=%h exp=12345678", ALU_result_W); end
    checks++; if (rd_W !== 5'd5) begin errors++; $display("FAIL alu_rd_W got=%0d exp=5", rd_W); end
    checks++; if (RegWrite_W !== 1'b1) begin errors++; $display("FAIL alu_RegWrite_W got=%0h exp=1", RegWrite_W); end
    checks++; if (rdata_W !== 32'h0) begin errors++; $display("FAIL alu_rdata_W got=%h exp=0", rdata_W); end
    checks++; if (PC_4W !== 32'h1234567C) begin errors++; $display("FAIL alu_PC_4W got=%h exp=1234567c", PC_4W); end
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b0, 1'b1, 5'd6);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL inv_req got=%0h exp=0", dmem_req); end
    tick();
    checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL inv_RegWrite_W got=%0h exp=0", RegWrite_W); end
    checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL inv_valid_W got=%0h exp=0", valid_W); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4001, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 5'd14);
`ifdef MISALIGN_TRAP_EN
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got=%0h exp=0", dmem_req); end
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL mis_stall got=%0h exp=0", stall_M); end
    tick();
    checks++; if (misalign_W !== 1'b1) begin errors++; $display("FAIL mis_flag got=%0h exp=1", misalign_W); end
    checks++; if (RegWrite_W !== 1'b0) begin errors++; $display("FAIL mis_RegWrite_W got=%0h exp=0", RegWrite_W); end
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 5'd14);
    tick();
    checks++; if (misalign_W !== 1'b0) begin errors++; $display("FAIL mis_clear got=%0h exp=0", misalign_W); end
`else
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mis_req got=%0h exp=1", dmem_req); end
    checks++; if (dmem_addr !== 32'h4000) begin errors++; $display("FAIL mis_addr got=%h exp=00004000", dmem_addr); end
    dmem_ready = 1'b1; #1;
    tick();
    checks++; if (rdata_W !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_lw_rdata got=%h exp=cafef00d", rdata_W); end
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h2003, 32'h00004321, 32'h0, 1'b1, 1'b0, 5'd0);
    checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL mis_sh_be got=%b exp=1100", dmem_be); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_wait();
    test_store_lanes();
    test_back_to_back();
    test_alu_op();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM boundary and the writeback stage.
- Issues load/store requests to the data memory over a req/ready handshake. Generates byte enables and store-data lane replication. Formats load data (sign/zero extension).
- Contains the MEM/WB pipeline register that drives the writeback stage inputs.
- Raises a stall to the hazard unit while a memory access is outstanding.

Parameters:
- ADDR_WIDTH, 32, address width of PC and data memory.
- DAT_WIDTH, 32, data width. Fixed at 32 for the byte-lane logic.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_M  in  1  instruction in MEM stage is valid.
- MemRead_M  in  1  load.
- MemWrite_M  in  1  store.
- MemtoReg_M  in  1  writeback selects memory data.
- RegWrite_M  in  1  instruction writes the register file.
- funct3_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_M  in  5  destination register.
- ALU_result_M  in  DAT_WIDTH  effective address, or ALU result for non-memory ops.
- wdata_M  in  DAT_WIDTH  store data (rs2).
- PC_4M  in  ADDR_WIDTH  PC+4.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_WIDTH  word-aligned address {ALU_result_M[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DAT_WIDTH  lane-replicated store data.
- dmem_rdata  in  DAT_WIDTH  read data, valid when dmem_ready=1.
- dmem_ready  in  1  access complete this cycle.
- stall_M  out  1  hold IF/ID/EX/MEM stages.
- valid_W  out  1  MEM/WB valid.
- MemtoReg_W  out  1  registered MemtoReg_M.
- RegWrite_W  out  1  registered RegWrite_M, qualified by valid.
- rd_W  out  5  registered rd_M.
- PC_4W  out  ADDR_WIDTH  registered PC_4M.
- ALU_result_W  out  DAT_WIDTH  registered ALU_result_M.
- rdata_W  out  DAT_WIDTH  registered, formatted load data.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE.
  - All _W outputs clear to 0.
- While rst_n=0:
  - dmem_req and stall_M are forced to 0 combinationally.
  - A transaction in flight is abandoned; a late dmem_ready is ignored.
- Access condition: mem_op = valid_M & (MemRead_M | MemWrite_M).
- FSM has two states:
  - IDLE:
    - dmem_req = mem_op; dmem_we = MemWrite_M.
    - If mem_op and dmem_ready: zero-wait completion. Stay in IDLE, stall_M=0.
    - If mem_op and !dmem_ready: next state is WAIT; stall_M=1.
  - WAIT:
    - dmem_req=1. Address, be and wdata stay stable because upstream is stalled.
    - If dmem_ready: next state IDLE, stall_M=0 this cycle.
    - Otherwise stall_M=1.
- stall_M is combinational: mem_op & !dmem_ready, in either state.
- MEM/WB register update, on every edge with rst_n=1:
  - stall_M=0: all _W outputs load from the _M inputs; RegWrite_W = RegWrite_M & valid_M; rdata_W = formatted dmem_rdata for loads, else 0.
  - stall_M=1: insert a bubble. valid_W=0 and RegWrite_W=0; other _W fields hold.
- Latency: MEM to WB is 1 cycle with zero-wait memory; 1+N cycles with N wait cycles.
- Byte enables, with off = ALU_result_M[1:0]:
  - SB: 4'b0001<<off.
  - SH: 4'b0011<<{off[1],1'b0}.
  - SW: 4'b1111.
  - Loads: dmem_be = 4'b1111.
- Store data replication:
  - SB: byte replicated into all 4 lanes.
  - SH: halfword replicated into both halves.
  - SW: unchanged.
- Load formatting:
  - Select byte lane off, or halfword lane off[1].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: pass through.
  - Other funct3 codes: treated as LW.
- Non-memory instructions (mem_op=0): no request; they pass straight to the MEM/WB register.
- Misaligned SH/LH (off[0]=1) or SW/LW (off≠0): the low address bits are ignored. The access uses the aligned lane.
- Back-to-back accesses in consecutive cycles must work with no idle cycle between them.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_W (1 bit), registered alongside the other _W outputs.
  - A misaligned access (half with off[0]=1, word with off≠0) issues no request (dmem_req=0) and causes no stall.
  - It sets misalign_W=1 and forces RegWrite_W=0 for that instruction.
- Undefined: port absent; misaligned addresses use the aligned lane as described above.

Test Plan:
- Reset mid-WAIT: LW in progress with dmem_ready=0, rst_n=0 for one edge → next cycle dmem_req=0, stall_M=0, valid_W=0, RegWrite_W=0, rdata_W=0.
- Zero-wait LB: addr 0x1003, dmem_rdata=0x80_00_00_00, dmem_ready=1 → 1 cycle later rdata_W=0xFFFFFF80, valid_W=1, stall_M never asserted. Same access as LBU → rdata_W=0x00000080.
- SH with 2 wait states: addr 0x2002, wdata_M=0x0000BEEF, dmem_ready low for 2 cycles → stall_M=1 for 2 cycles; dmem_be=4'b1100 and dmem_wdata=0xBEEFBEEF held stable; valid_W=0 bubbles during the stall; then one valid_W=1 with RegWrite_W=0.
- LHU/LH back-to-back: addr 0x3002, dmem_rdata=0xF00D1234, ready=1 each cycle → consecutive rdata_W = 0x0000F00D, then 0xFFFFF00D.
- ALU op (valid_M=1, no mem op): ALU_result_M=0x12345678, rd_M=5 → dmem_req=0; next cycle ALU_result_W=0x12345678, rd_W=5, RegWrite_W=1.
- With MISALIGN_TRAP_EN: LW at 0x4001 → dmem_req=0, stall_M=0, then misalign_W=1 and RegWrite_W=0.
